processor_16x4: RTL and testbench

- 4-bit, 16-register accumulator-free processor core.
- Accepts one 12-bit instruction from an external source and executes it through a 4-state multicycle FSM (FETCH, DECODE, EXECUTE, WRITEBACK).
- Writes the result to a 16x4 register file and exposes it on resultReg.
- Serves as the datapath/control leaf of the small processor design; there is no program memory or PC inside.

---
 rtl/processor_16x4.sv | 91 +++++++++
 tb/tb_processor_16x4.sv | 132 +++++++++++++
 2 files changed

// File: rtl/processor_16x4.sv
// 4-bit, 16-register multicycle core: FETCH, DECODE, EXECUTE and WRITEBACK take one clock each.
// It executes the 12-bit word present on instructionReg at each FETCH edge.
module processor_16x4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] instructionReg,
    output logic [3:0]  resultReg
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t      state_reg;
    logic [11:0] ir_reg;
    logic [3:0]  op_a_reg;
    logic [3:0]  op_b_reg;
    logic [3:0]  temp_reg;
    logic [3:0]  result_reg;
    logic [3:0]  regs_reg [16];
    logic [3:0]  alu_next;

    logic       ir_imm;
    logic [2:0] ir_op;
    logic [3:0] ir_rd;
    logic [3:0] ir_rs;

    assign ir_imm    = ir_reg[11];
    assign ir_op     = ir_reg[10:8];
    assign ir_rd     = ir_reg[7:4];
    assign ir_rs     = ir_reg[3:0];
    assign resultReg = result_reg;

    // For immediate moves, operand B already holds imm4, so the ALU passes it through.
    always_comb begin
        alu_next = '0;
        if (ir_imm) begin
            alu_next = op_b_reg;
        end else begin
            case (ir_op)
                3'b000:  alu_next = op_a_reg + op_b_reg;
                3'b001:  alu_next = op_a_reg - op_b_reg;
                3'b010:  alu_next = {op_a_reg[2:0], 1'b0};
                3'b011:  alu_next = {1'b0, op_a_reg[3:1]};
                3'b100:  alu_next = op_a_reg & op_b_reg;
                3'b101:  alu_next = op_a_reg | op_b_reg;
                3'b110:  alu_next = op_a_reg ^ op_b_reg;
                default: alu_next = ~op_b_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= FETCH;
            ir_reg     <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            temp_reg   <= '0;
            result_reg <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                FETCH: begin
                    ir_reg    <= instructionReg;
                    state_reg <= DECODE;
                end
                DECODE: begin
                    op_a_reg  <= regs_reg[ir_rd];
                    op_b_reg  <= ir_imm ? ir_rs : regs_reg[ir_rs];
                    state_reg <= EXECUTE;
                end
                EXECUTE: begin
                    temp_reg  <= alu_next;
                    state_reg <= WRITEBACK;
                end
                default: begin
                    regs_reg[ir_rd] <= temp_reg;
                    result_reg      <= temp_reg;
                    state_reg       <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processor_16x4.sv
// Directed bench for processor_16x4: a vector table of 4-cycle instruction slots
// plus hand sequences for reset, re-execution and the instruction sampling window.
module tb_processor_16x4;

    logic        clk;
    logic        rst;
    logic [11:0] instructionReg;
    logic [3:0]  resultReg;

    int checks = 0;
    int errors = 0;
    logic [3:0] last_exp;

    processor_16x4 dut (
        .clk            (clk),
        .rst            (rst),
        .instructionReg (instructionReg),
        .resultReg      (resultReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] instr;
        logic [3:0]  expected;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] mov(input logic [3:0] rd, input logic [3:0] imm);
        return {1'b1, 3'b000, rd, imm};
    endfunction

    function automatic logic [11:0] alu(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs);
        return {1'b0, op, rd, rs};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: resultReg=%h required %h", name, act, exp);
        end else begin
            $display("ok   %s: resultReg=%h", name, act);
        end
    endtask

    // One instruction slot: the caller is just past a writeback (or reset release),
    // so the next rising edge is a FETCH edge.
    task automatic exec(input string name, input logic [11:0] instr, input logic [3:0] exp);
        instructionReg = instr;
        @(posedge clk);
        #1 check({name, "/hold"}, resultReg, last_exp);
        repeat (3) @(posedge clk);
        #1 check(name, resultReg, exp);
        last_exp = exp;
    endtask

    initial begin
        rst            = 1'b0;
        instructionReg = '0;
        last_exp       = '0;
        #1 check("reset_state", resultReg, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Preload nonzero contents, then reset asynchronously mid-instruction.
        exec("mov_r3_6", mov(4'd3, 4'h6), 4'h6);
        exec("mov_r4_2", mov(4'd4, 4'h2), 4'h2);
        instructionReg = mov(4'd3, 4'h9);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset", resultReg, 4'h0);
        last_exp = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        exec("add_r3_r4_cleared", alu(3'b000, 4'd3, 4'd4), 4'h0);

        vecs.push_back('{"mov_r0_3",    mov(4'd0, 4'h3), 4'h3});
        vecs.push_back('{"mov_r1_5",    mov(4'd1, 4'h5), 4'h5});
        vecs.push_back('{"mov_r2_7",    mov(4'd2, 4'h7), 4'h7});
        vecs.push_back('{"mov_r14_f",   mov(4'd14, 4'hF), 4'hF});
        vecs.push_back('{"mov_r15_a",   mov(4'd15, 4'hA), 4'hA});
        vecs.push_back('{"add_r1_r0",   alu(3'b000, 4'd1, 4'd0), 4'h8});
        vecs.push_back('{"sub_r1_r2",   alu(3'b001, 4'd1, 4'd2), 4'h1});
        vecs.push_back('{"and_r1_r15",  alu(3'b100, 4'd1, 4'd15), 4'h0});
        vecs.push_back('{"xor_r14_r2",  alu(3'b110, 4'd14, 4'd2), 4'h8});
        vecs.push_back('{"mov_r5_f",    mov(4'd5, 4'hF), 4'hF});
        vecs.push_back('{"mov_r6_1",    mov(4'd6, 4'h1), 4'h1});
        vecs.push_back('{"add_wrap",    alu(3'b000, 4'd5, 4'd6), 4'h0});
        vecs.push_back('{"mov_r7_0",    mov(4'd7, 4'h0), 4'h0});
        vecs.push_back('{"sub_borrow",  alu(3'b001, 4'd7, 4'd6), 4'hF});
        vecs.push_back('{"mov_r8_9",    mov(4'd8, 4'h9), 4'h9});
        vecs.push_back('{"shl_9",       alu(3'b010, 4'd8, 4'd0), 4'h2});
        vecs.push_back('{"mov_r9_9",    mov(4'd9, 4'h9), 4'h9});
        vecs.push_back('{"shr_9",       alu(3'b011, 4'd9, 4'd0), 4'h4});
        vecs.push_back('{"not_r15",     alu(3'b111, 4'd10, 4'd15), 4'h5});
        vecs.push_back('{"or_5_a",      alu(3'b101, 4'd10, 4'd15), 4'hF});
        vecs.push_back('{"mov_r11_3",   mov(4'd11, 4'h3), 4'h3});
        vecs.push_back('{"add_rd_eq_rs", alu(3'b000, 4'd11, 4'd11), 4'h6});
        vecs.push_back('{"mov_op_ignored", {1'b1, 3'b111, 4'd3, 4'h4}, 4'h4});
        vecs.push_back('{"sub_r3_r0",   alu(3'b001, 4'd3, 4'd0), 4'h1});

        foreach (vecs[i]) begin
            exec(vecs[i].name, vecs[i].instr, vecs[i].expected);
        end

        // Re-execution: a held ADD applies again on every slot.
        exec("mov_r1_5_again", mov(4'd1, 4'h5), 4'h5);
        exec("add_hold_1st", alu(3'b000, 4'd1, 4'd0), 4'h8);
        exec("add_hold_2nd", alu(3'b000, 4'd1, 4'd0), 4'hB);

        // Sampling window: words changed after FETCH do not affect the instruction in flight.
        instructionReg = mov(4'd12, 4'h6);
        @(posedge clk);
        #1 instructionReg = mov(4'd12, 4'hD);
        @(posedge clk);
        #1 instructionReg = alu(3'b000, 4'd12, 4'd12);
        repeat (2) @(posedge clk);
        #1 check("window_in_flight", resultReg, 4'h6);
        last_exp = 4'h6;
        exec("window_next_word", alu(3'b000, 4'd12, 4'd12), 4'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
